wptr_full: RTL

//   Write-side pointer and full-flag logic of the asynchronous FIFO. Runs in the write clock domain.

---
 rtl/wptr_full_if.sv | 42 ++++
 rtl/wptr_full.sv | 83 ++++++++
 2 files changed

// File: rtl/wptr_full_if.sv
// Write-side port bundle of the asynchronous FIFO.
// The producer side (master) drives the push request and supplies the
// read pointer that has already been synchronised into the write clock domain.
// The pointer/full block (slave) returns the RAM write strobe and address,
// the Gray write pointer, and the fill status.
interface wptr_full_if #(
    parameter int ADDR_SIZE = 3
);
    logic                 wpush;
    logic [ADDR_SIZE:0]   sync_rptr;
    logic                 wen;
    logic [ADDR_SIZE-1:0] waddr;
    logic [ADDR_SIZE:0]   wptr;
    logic                 wfull;
    logic                 walmost_full;
    logic [ADDR_SIZE:0]   wcount;
    logic                 wovf;

    modport master (
        output wpush,
        output sync_rptr,
        input  wen,
        input  waddr,
        input  wptr,
        input  wfull,
        input  walmost_full,
        input  wcount,
        input  wovf
    );

    modport slave (
        input  wpush,
        input  sync_rptr,
        output wen,
        output waddr,
        output wptr,
        output wfull,
        output walmost_full,
        output wcount,
        output wovf
    );
endinterface

// File: rtl/wptr_full.sv
// Write-side pointer and full-flag logic of the asynchronous FIFO (wclk domain).
// Keeps a binary write pointer for RAM addressing and a Gray copy for
// crossing into the read domain. The read pointer arrives already
// synchronised into wclk. It is therefore stale, so full, almost-full and the
// count can only err on the safe side: late deassertion or over-estimation.
module wptr_full #(
    parameter int ADDR_SIZE    = 3,
    parameter int AFULL_THRESH = 6
) (
    input  logic          wclk,
    input  logic          wrst,
    wptr_full_if.slave    bus
);
    localparam int PW = ADDR_SIZE + 1;
    localparam logic [PW-1:0] AFULL_VAL = PW'(AFULL_THRESH);

    logic [PW-1:0] r_wbin;
    logic [PW-1:0] r_wptr;
    logic          r_wfull;
    logic          r_walmost_full;
    logic [PW-1:0] r_wcount;
    logic          r_wovf;

    logic          w_wen;
    logic [PW-1:0] w_wbin_next;
    logic [PW-1:0] w_wgray_next;
    logic [PW-1:0] w_rbin;
    logic [PW-1:0] w_rgray_full;
    logic [PW-1:0] w_count_next;
    logic          w_full_next;
    logic          w_afull_next;

    // A push is accepted only while the registered full flag is clear.
    assign w_wen        = bus.wpush & ~r_wfull;
    assign w_wbin_next  = r_wbin + {{ADDR_SIZE{1'b0}}, w_wen};
    assign w_wgray_next = w_wbin_next ^ (w_wbin_next >> 1);

    // Convert the synchronised Gray read pointer to binary, MSB first.
    always_comb begin
        // NOTE: default first so every bit is written on every path (no latch).
        w_rbin = '0;
        w_rbin[ADDR_SIZE] = bus.sync_rptr[ADDR_SIZE];
        for (int i = ADDR_SIZE - 1; i >= 0; i--) begin
            w_rbin[i] = w_rbin[i+1] ^ bus.sync_rptr[i];
        end
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer:
    // in Gray code, that means the top two bits are inverted and the rest are equal.
    assign w_rgray_full = {~bus.sync_rptr[ADDR_SIZE:ADDR_SIZE-1],
                           bus.sync_rptr[ADDR_SIZE-2:0]};
    assign w_full_next  = (w_wgray_next == w_rgray_full);
    assign w_count_next = w_wbin_next - w_rbin;
    assign w_afull_next = (w_count_next >= AFULL_VAL);

    // Pointer and status registers; reset takes priority and clears all state.
    always_ff @(posedge wclk) begin
        // NOTE: non-blocking assignments so all registers update from pre-edge values.
        if (wrst) begin
            r_wbin         <= '0;
            r_wptr         <= '0;
            r_wfull        <= 1'b0;
            r_walmost_full <= 1'b0;
            r_wcount       <= '0;
            r_wovf         <= 1'b0;
        end else begin
            r_wbin         <= w_wbin_next;
            r_wptr         <= w_wgray_next;
            r_wfull        <= w_full_next;
            r_walmost_full <= w_afull_next;
            r_wcount       <= w_count_next;
            r_wovf         <= r_wovf | (bus.wpush & r_wfull);
        end
    end

    assign bus.wen          = w_wen;
    assign bus.waddr        = r_wbin[ADDR_SIZE-1:0];
    assign bus.wptr         = r_wptr;
    assign bus.wfull        = r_wfull;
    assign bus.walmost_full = r_walmost_full;
    assign bus.wcount       = r_wcount;
    assign bus.wovf         = r_wovf;
endmodule
